baslangic_getirici: RTL

- Instruction-fetch initiator that drives the boot ROM's address/enable interface, and the requester side of that ROM.
- Keeps the boot program counter and issues one word address per cycle.
- Absorbs the ROM's 1-cycle registered read latency and delivers words plus their addresses to the decode stage over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of in-flight and buffered words.

---
 rtl/baslangic_getirici.sv | 116 +++++++++++
 1 files changed

// File: rtl/baslangic_getirici.sv
// Boot-ROM instruction fetch front end: PC, one-cycle ROM latency absorption, output FIFO, redirect/flush.
// Optional transfer counter port sayac_c is enabled by defining BASLANGIC_GETIRICI_SAYAC_EN.
module baslangic_getirici #(
  parameter logic [31:0] BASLANGIC_ADRES = 32'h0000_0000,
  parameter int          ROM_KELIME      = 41,
  parameter int          FIFO_DERINLIK   = 2
) (
  input  logic        clk_g,
  input  logic        rst_g,
  output logic [31:0] bellek_adres_c,
  output logic        bellek_ena_c,
  input  logic [31:0] bellek_buyruk_g,
  input  logic        dallan_g,
  input  logic [31:0] dallan_adres_g,
  output logic [31:0] buyruk_c,
  output logic [31:0] buyruk_adres_c,
  output logic        gecerli_c,
  input  logic        hazir_g,
  output logic        sinir_hata_c,
  output logic        hiza_hata_c
`ifdef BASLANGIC_GETIRICI_SAYAC_EN
  ,
  output logic [31:0] sayac_c
`endif
);

  localparam int          PW      = (FIFO_DERINLIK > 1) ? $clog2(FIFO_DERINLIK) : 1;
  localparam int          CW      = $clog2(FIFO_DERINLIK + 1);
  localparam logic [29:0] ROM_SON = 30'(ROM_KELIME);

  logic [31:0]   pc;
  logic          vld_p1;
  logic [31:0]   adres_p1;
  logic [31:0]   veri_mem  [FIFO_DERINLIK];
  logic [31:0]   adres_mem [FIFO_DERINLIK];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic pop;
  logic room;
  logic in_range;
  logic try_issue;
  logic issue;
  int   occ_sonra;

  function automatic logic [PW-1:0] ptr_ilerle(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DERINLIK - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pop       = gecerli_c && hazir_g;
    // Slots needed after this edge: surviving words, the word landing now, and the new request.
    occ_sonra = int'(count) - int'(pop) + int'(vld_p1) + 1;
    room      = (occ_sonra <= FIFO_DERINLIK);
    in_range  = (pc[31:2] < ROM_SON);
    try_issue = rst_g && !dallan_g && !sinir_hata_c && room;
    issue     = try_issue && in_range;
  end

  assign bellek_adres_c = pc;
  assign bellek_ena_c   = issue;
  assign gecerli_c      = (count != '0);
  assign buyruk_c       = gecerli_c ? veri_mem[rd_ptr]  : '0;
  assign buyruk_adres_c = gecerli_c ? adres_mem[rd_ptr] : '0;

  // Stage p0 -> p1: request issue, PC advance, FIFO bookkeeping
  always_ff @(posedge clk_g) begin
    if (!rst_g) begin
      pc           <= BASLANGIC_ADRES;
      vld_p1       <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      sinir_hata_c <= 1'b0;
      hiza_hata_c  <= 1'b0;
    end else if (dallan_g) begin
      // Flushing the pointers also discards the response landing on this edge.
      pc     <= {dallan_adres_g[31:2], 2'b00};
      vld_p1 <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (dallan_adres_g[1:0] != 2'b00) hiza_hata_c <= 1'b1;
      if (dallan_adres_g[31:2] < ROM_SON) sinir_hata_c <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) pc <= pc + 32'd4;
      if (try_issue && !in_range) sinir_hata_c <= 1'b1;
      if (vld_p1) wr_ptr <= ptr_ilerle(wr_ptr);
      if (pop) rd_ptr <= ptr_ilerle(rd_ptr);
      case ({vld_p1, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Stage p1 -> FIFO: capture ROM word with the address it was fetched from
  always_ff @(posedge clk_g) begin
    if (issue) adres_p1 <= pc;
    if (vld_p1) begin
      veri_mem[wr_ptr]  <= bellek_buyruk_g;
      adres_mem[wr_ptr] <= adres_p1;
    end
  end

`ifdef BASLANGIC_GETIRICI_SAYAC_EN
  always_ff @(posedge clk_g) begin
    if (!rst_g) sayac_c <= '0;
    else if (pop && (sayac_c != 32'hFFFF_FFFF)) sayac_c <= sayac_c + 32'd1;
  end
`endif

endmodule
